// File: rtl/mc_scoreboard.sv
// Purpose : RAW scoreboard for the three multi-cycle units (M, A, FPU); holds ID while a result is pending.
// Latency : issue is visible on slot_busy/raw_stall one cycle after the issue edge; the stall drops WB_DELAY cycles after done.
// Backpr. : an issue aimed at a non-idle slot is refused and flagged on issue_stall; the slot keeps its contents.
//
// Ports:
//   clk, reset_n          core clock, asynchronous active-low reset
//   issue_valid/unit/rd/rd_fp   multi-cycle op entering EX (unit 3 is reserved and ignored)
//   unit_done[2:0]        per-unit completion pulse, bit index = unit code
//   flush                 abandons every tracked op at the next edge
//   id_rs1/rs2, id_fp_rs1..3    ID-stage source registers
//   raw_stall             an ID source matches a tracked destination
//   issue_stall           issuing op targets a non-idle slot
//   slot_busy[2:0]        slot state != IDLE, per unit
//   fp_pending            FPU slot != IDLE (holds FFLAGS/FCSR accesses)
//   stall_cycles          saturating count of cycles with raw_stall=1

module mc_scoreboard #(
   parameter int unsigned WB_DELAY = 1,   // legal 1..7
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue_valid,
   input  logic [1:0]       issue_unit,
   input  logic [4:0]       issue_rd,
   input  logic             issue_rd_fp,
   input  logic [2:0]       unit_done,
   input  logic             flush,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_fp_rs1,
   input  logic [4:0]       id_fp_rs2,
   input  logic [4:0]       id_fp_rs3,
   output logic             raw_stall,
   output logic             issue_stall,
   output logic [2:0]       slot_busy,
   output logic             fp_pending,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int NUM_SLOTS = 3;

   // Loaded into the countdown when a unit reports done. The slot leaves
   // WB_PENDING on the cycle the count reads 1, so WB_PENDING lasts
   // exactly WB_DELAY cycles.
   localparam logic [2:0]       WB_CNT_INIT = 3'(WB_DELAY);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_WB   = 2'd2
   } slot_state_e;

   slot_state_e state_q [NUM_SLOTS];
   slot_state_e state_d [NUM_SLOTS];
   logic [4:0]  rd_q    [NUM_SLOTS];
   logic [4:0]  rd_d    [NUM_SLOTS];
   logic        fp_q    [NUM_SLOTS];
   logic        fp_d    [NUM_SLOTS];
   logic [2:0]  cnt_q   [NUM_SLOTS];
   logic [2:0]  cnt_d   [NUM_SLOTS];

   logic [2:0]       issue_sel;
   logic [2:0]       slot_match;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   // ------------------------------------------------------------------
   // Issue decode: one-hot slot select, reserved unit code selects none.
   // ------------------------------------------------------------------
   always_comb begin
      issue_sel = 3'b000;
      if (issue_valid) begin
         case (issue_unit)
            2'd0:    issue_sel = 3'b001;
            2'd1:    issue_sel = 3'b010;
            2'd2:    issue_sel = 3'b100;
            default: issue_sel = 3'b000;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Slot state registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int u = 0; u < NUM_SLOTS; u++) begin
            state_q[u] <= S_IDLE;
            rd_q[u]    <= 5'd0;
            fp_q[u]    <= 1'b0;
            cnt_q[u]   <= 3'd0;
         end
      end else begin
         for (int u = 0; u < NUM_SLOTS; u++) begin
            state_q[u] <= state_d[u];
            rd_q[u]    <= rd_d[u];
            fp_q[u]    <= fp_d[u];
            cnt_q[u]   <= cnt_d[u];
         end
      end
   end

   // ------------------------------------------------------------------
   // Slot next-state logic. flush beats done and issue. An issue is only
   // taken from IDLE, so a same-cycle done/issue on a BUSY slot lets the
   // done win and the issue is refused (issue_stall reports it).
   // ------------------------------------------------------------------
   always_comb begin
      for (int u = 0; u < NUM_SLOTS; u++) begin
         state_d[u] = state_q[u];
         rd_d[u]    = rd_q[u];
         fp_d[u]    = fp_q[u];
         cnt_d[u]   = cnt_q[u];

         if (flush) begin
            state_d[u] = S_IDLE;
            cnt_d[u]   = 3'd0;
         end else begin
            case (state_q[u])
               S_IDLE: begin
                  if (issue_sel[u]) begin
                     state_d[u] = S_BUSY;
                     rd_d[u]    = issue_rd;
                     fp_d[u]    = issue_rd_fp;
                  end
               end
               S_BUSY: begin
                  if (unit_done[u]) begin
                     state_d[u] = S_WB;
                     cnt_d[u]   = WB_CNT_INIT;
                  end
               end
               S_WB: begin
                  // done pulses here are stale and ignored.
                  if (cnt_q[u] <= 3'd1) begin
                     state_d[u] = S_IDLE;
                     cnt_d[u]   = 3'd0;
                  end else begin
                     cnt_d[u]   = cnt_q[u] - 3'd1;
                  end
               end
               default: begin
                  state_d[u] = S_IDLE;
                  cnt_d[u]   = 3'd0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs, from registered slot state only (plus the issue request
   // for issue_stall). The op issuing this cycle is deliberately not
   // compared: the EX-stage hazard check already covers its issue cycle.
   // ------------------------------------------------------------------
   always_comb begin
      slot_busy  = 3'b000;
      slot_match = 3'b000;
      for (int u = 0; u < NUM_SLOTS; u++) begin
         slot_busy[u] = (state_q[u] != S_IDLE);
         if (state_q[u] != S_IDLE) begin
            if (fp_q[u]) begin
               // f0 is an ordinary FP register, so no zero exclusion.
               slot_match[u] = (rd_q[u] == id_fp_rs1) ||
                               (rd_q[u] == id_fp_rs2) ||
                               (rd_q[u] == id_fp_rs3);
            end else begin
               // x0 writes are tracked for occupancy but never hazard.
               slot_match[u] = (rd_q[u] != 5'd0) &&
                               ((rd_q[u] == id_rs1) || (rd_q[u] == id_rs2));
            end
         end
      end
   end

   assign raw_stall   = |slot_match;
   assign fp_pending  = slot_busy[2];
   // Conservative: a slot still in WB_PENDING is not overwritten either.
   assign issue_stall = |(issue_sel & slot_busy);

   // ------------------------------------------------------------------
   // Saturating stall-cycle counter; survives flush, cleared by reset.
   // ------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (raw_stall && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_mc_scoreboard.sv
module tb_mc_scoreboard;

   logic        clk;
   logic        reset_n;
   logic        issue_valid;
   logic [1:0]  issue_unit;
   logic [4:0]  issue_rd;
   logic        issue_rd_fp;
   logic [2:0]  unit_done;
   logic        flush;
   logic [4:0]  id_rs1, id_rs2, id_fp_rs1, id_fp_rs2, id_fp_rs3;

   logic        raw_stall, issue_stall, fp_pending;
   logic [2:0]  slot_busy;
   logic [31:0] stall_cycles;

   logic        raw_stall3, issue_stall3, fp_pending3;
   logic [2:0]  slot_busy3;
   logic [3:0]  stall_cycles3;

   int n_vec = 0;
   int n_mis = 0;

   mc_scoreboard #(.WB_DELAY(1), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
      .issue_rd_fp(issue_rd_fp), .unit_done(unit_done), .flush(flush),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_fp_rs1(id_fp_rs1),
      .id_fp_rs2(id_fp_rs2), .id_fp_rs3(id_fp_rs3),
      .raw_stall(raw_stall), .issue_stall(issue_stall), .slot_busy(slot_busy),
      .fp_pending(fp_pending), .stall_cycles(stall_cycles)
   );

   // Longer write-back window and a narrow counter to reach saturation.
   mc_scoreboard #(.WB_DELAY(3), .CNT_W(4)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
      .issue_rd_fp(issue_rd_fp), .unit_done(unit_done), .flush(flush),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_fp_rs1(id_fp_rs1),
      .id_fp_rs2(id_fp_rs2), .id_fp_rs3(id_fp_rs3),
      .raw_stall(raw_stall3), .issue_stall(issue_stall3), .slot_busy(slot_busy3),
      .fp_pending(fp_pending3), .stall_cycles(stall_cycles3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [1:0] iu;
      logic [4:0] ird;
      logic       ifp;
      logic [2:0] done;
      logic       fl;
      logic [4:0] rs1, rs2, f1, f2, f3;
      logic       e_raw;
      logic       e_ist;
      logic [2:0] e_busy;
      int         e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic iv, input logic [1:0] iu, input logic [4:0] ird, input logic ifp,
      input logic [2:0] done, input logic fl,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] f1, input logic [4:0] f2, input logic [4:0] f3,
      input logic e_raw, input logic e_ist, input logic [2:0] e_busy, input int e_cnt);
      vec_t v;
      v.iv = iv; v.iu = iu; v.ird = ird; v.ifp = ifp; v.done = done; v.fl = fl;
      v.rs1 = rs1; v.rs2 = rs2; v.f1 = f1; v.f2 = f2; v.f3 = f3;
      v.e_raw = e_raw; v.e_ist = e_ist; v.e_busy = e_busy; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      issue_valid = 1'b0; issue_unit = 2'd0; issue_rd = 5'd0; issue_rd_fp = 1'b0;
      unit_done = 3'b000; flush = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_fp_rs1 = 5'd0; id_fp_rs2 = 5'd0; id_fp_rs3 = 5'd0;
   endtask

   initial begin
      // Inputs are applied on the falling edge; outputs checked 2 time
      // units later, well before the rising edge that consumes them.
      //              iv iu ird fp done  fl rs1 rs2 f1 f2 f3  raw ist busy   cnt
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
      // M rd=x5, done in the 4th busy cycle, id_rs1=5 held
      vecs.push_back(mk(1, 0, 5, 0, 3'b000, 0, 5, 0, 0, 0, 0, 0, 0, 3'b000, 0));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 5, 0, 0, 0, 0, 1, 0, 3'b001, 0));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 5, 0, 0, 0, 0, 1, 0, 3'b001, 1));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 5, 0, 0, 0, 0, 1, 0, 3'b001, 2));
      vecs.push_back(mk(0, 0, 0, 0, 3'b001, 0, 5, 0, 0, 0, 0, 1, 0, 3'b001, 3));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 5, 0, 0, 0, 0, 1, 0, 3'b001, 4));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 5, 0, 0, 0, 0, 0, 0, 3'b000, 5));
      // A rd=x0 with id_rs1=0: tracked but never a hazard
      vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5));
      // FPU rd=f0: matches via fp_rs3, then fp_rs1, then fp_rs2 in WB
      vecs.push_back(mk(1, 2, 0, 1, 3'b000, 0, 0, 0, 1, 2, 0, 0, 0, 3'b000, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2, 0, 1, 0, 3'b100, 5));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2, 3, 0, 0, 3'b100, 6));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 3, 1, 0, 3'b100, 6));
      vecs.push_back(mk(0, 0, 0, 0, 3'b100, 0, 0, 0, 5, 5, 5, 0, 0, 3'b100, 7));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 5, 1, 0, 3'b100, 7));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 5, 0, 0, 3'b000, 8));
      // M rd=9, then same-cycle done + reissue: done wins, issue refused
      vecs.push_back(mk(1, 0, 9, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8));
      vecs.push_back(mk(1, 0,10, 0, 3'b001, 0,10, 0, 0, 0, 0, 0, 1, 3'b001, 8));
      vecs.push_back(mk(1, 0,11, 0, 3'b000, 0, 9, 0, 0, 0, 0, 1, 1, 3'b001, 8));
      vecs.push_back(mk(1, 0,12, 0, 3'b000, 0, 9,12, 0, 0, 0, 0, 0, 3'b000, 9));
      vecs.push_back(mk(1, 3,12, 0, 3'b000, 0, 0,12, 0, 0, 0, 1, 0, 3'b001, 9));
      vecs.push_back(mk(1, 3, 1, 0, 3'b001, 0,12, 0, 0, 0, 0, 1, 0, 3'b001,10));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001,11));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000,11));
      // fill all three slots, then flush with done[1] and an issue
      vecs.push_back(mk(1, 0, 3, 0, 3'b000, 0, 0, 0,31,31,31, 0, 0, 3'b000,11));
      vecs.push_back(mk(1, 1, 4, 0, 3'b000, 0, 0, 0,31,31,31, 0, 0, 3'b001,11));
      vecs.push_back(mk(1, 2, 6, 1, 3'b000, 0, 0, 0,31,31,31, 0, 0, 3'b011,11));
      vecs.push_back(mk(1, 0, 7, 0, 3'b010, 1, 4, 0,31,31,31, 1, 1, 3'b111,11));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 3, 4, 6, 6, 6, 0, 0, 3'b000,12));
      vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 3, 4, 6, 6, 6, 0, 0, 3'b000,12));

      drive_idle();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("reset raw_stall", {31'd0, raw_stall}, 32'd0);
      chk("reset slot_busy", {29'd0, slot_busy}, 32'd0);
      chk("reset stall_cycles", stall_cycles, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      // first table row is applied on the following falling edge

      foreach (vecs[i]) begin
         @(negedge clk);
         issue_valid = vecs[i].iv;  issue_unit = vecs[i].iu;
         issue_rd = vecs[i].ird;    issue_rd_fp = vecs[i].ifp;
         unit_done = vecs[i].done;  flush = vecs[i].fl;
         id_rs1 = vecs[i].rs1;      id_rs2 = vecs[i].rs2;
         id_fp_rs1 = vecs[i].f1;    id_fp_rs2 = vecs[i].f2;  id_fp_rs3 = vecs[i].f3;
         #2;
         chk($sformatf("v%0d raw_stall", i),    {31'd0, raw_stall},   {31'd0, vecs[i].e_raw});
         chk($sformatf("v%0d issue_stall", i),  {31'd0, issue_stall}, {31'd0, vecs[i].e_ist});
         chk($sformatf("v%0d slot_busy", i),    {29'd0, slot_busy},   {29'd0, vecs[i].e_busy});
         chk($sformatf("v%0d fp_pending", i),   {31'd0, fp_pending},  {31'd0, vecs[i].e_busy[2]});
         chk($sformatf("v%0d stall_cycles", i), stall_cycles,         32'(vecs[i].e_cnt));
      end

      // Reset asserted in the middle of a live op clears everything at once.
      @(negedge clk);
      drive_idle();
      issue_valid = 1'b1; issue_unit = 2'd0; issue_rd = 5'd8;
      @(negedge clk);
      drive_idle();
      id_rs1 = 5'd8;
      #2;
      chk("midop raw_stall before reset", {31'd0, raw_stall}, 32'd1);
      chk("midop slot_busy before reset", {29'd0, slot_busy}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("async reset slot_busy", {29'd0, slot_busy}, 32'd0);
      chk("async reset raw_stall", {31'd0, raw_stall}, 32'd0);
      chk("async reset stall_cycles", stall_cycles, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Long busy period: WB_DELAY=3 window and 4-bit counter saturation.
      for (int c = 0; c <= 24; c++) begin
         @(negedge clk);
         drive_idle();
         issue_valid = (c == 0);
         issue_rd    = 5'd7;
         id_rs1      = 5'd7;
         unit_done   = (c == 20) ? 3'b001 : 3'b000;
         #2;
         if (c == 16) begin
            chk("sat dut3 stall_cycles c16", {28'd0, stall_cycles3}, 32'd15);
            chk("sat dut stall_cycles c16", stall_cycles, 32'd15);
         end
         if (c == 21) begin
            chk("wb1 dut raw_stall c21", {31'd0, raw_stall}, 32'd1);
            chk("wb3 dut3 raw_stall c21", {31'd0, raw_stall3}, 32'd1);
         end
         if (c == 22) begin
            chk("wb1 dut slot_busy c22", {29'd0, slot_busy}, 32'd0);
            chk("wb1 dut raw_stall c22", {31'd0, raw_stall}, 32'd0);
            chk("wb3 dut3 raw_stall c22", {31'd0, raw_stall3}, 32'd1);
         end
         if (c == 23) begin
            chk("wb3 dut3 slot_busy c23", {29'd0, slot_busy3}, 32'd1);
            chk("wb3 dut3 raw_stall c23", {31'd0, raw_stall3}, 32'd1);
         end
         if (c == 24) begin
            chk("wb3 dut3 slot_busy c24", {29'd0, slot_busy3}, 32'd0);
            chk("wb3 dut3 raw_stall c24", {31'd0, raw_stall3}, 32'd0);
            chk("sat dut3 stall_cycles c24", {28'd0, stall_cycles3}, 32'd15);
            chk("dut stall_cycles c24", stall_cycles, 32'd21);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mc_scoreboard.md
Name: mc_scoreboard

Overview:
Tracks destination registers of in-flight multi-cycle operations: one slot each for the M unit, the A unit and the FPU. Raises a RAW stall for the ID-stage instruction while a result is still pending, and for a programmable number of cycles after the unit signals done. This covers the completion-to-EXMEM forwarding gap without stalling the whole operation. Sits beside the hazard detection unit; its outputs are ORed into stall_pc/stall_ifid/bubble_idex by the core top.

Parameters:
WB_DELAY, 1, cycles a slot stays WB_PENDING after done (legal 1..7)
CNT_W, 32, width of saturating stall-cycle performance counter

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
issue_valid  input  1  multi-cycle op entering EX this cycle
issue_unit  input  2  0=M, 1=A, 2=FPU, 3=reserved (ignored)
issue_rd  input  5  destination register of issuing op
issue_rd_fp  input  1  destination is FP register file
unit_done  input  3  per-unit completion pulse, bit index = unit code
flush  input  1  trap/flush; abandons all tracked ops
id_rs1  input  5  ID integer source 1
id_rs2  input  5  ID integer source 2
id_fp_rs1  input  5  ID FP source 1
id_fp_rs2  input  5  ID FP source 2
id_fp_rs3  input  5  ID FP source 3
raw_stall  output  1  ID source matches a tracked destination
issue_stall  output  1  issuing op targets a non-idle slot
slot_busy  output  3  slot state != IDLE, per unit
fp_pending  output  1  FPU slot != IDLE (feeds FFLAGS/FCSR CSR stall)
stall_cycles  output  CNT_W  cycles with raw_stall=1, saturating

Behaviour:
- Per slot: state {IDLE, BUSY, WB_PENDING}, rd[4:0], is_fp, cnt[2:0].
- Reset (async, reset_n=0): all slots IDLE, rd=0, is_fp=0, cnt=0, stall_cycles=0. All outputs are 0 during and immediately after reset.
- IDLE -> BUSY when issue_valid && issue_unit==u && slot u IDLE. Latch rd and is_fp.
- BUSY -> WB_PENDING on unit_done[u], with cnt=WB_DELAY.
- WB_PENDING: cnt decrements each cycle; when cnt==1, next state is IDLE. WB_PENDING therefore lasts exactly WB_DELAY cycles.
- unit_done[u] in IDLE or WB_PENDING: ignored.
- Issue to a non-IDLE slot: not accepted; slot unchanged. issue_stall = issue_valid && unit!=3 && slot[unit]!=IDLE (combinational). This is conservative; no overwrite of WB_PENDING.
- issue_unit==3: no state change, issue_stall=0.
- Same-cycle done and issue on the same unit: done takes effect; issue is rejected (slot was BUSY, so issue_stall=1).
- flush: every slot goes IDLE at the next edge. flush has priority over issue and done in the same cycle. stall_cycles is not cleared.
- raw_stall is combinational from registered slot state only. A slot matches when state != IDLE and either:
  - !is_fp, rd!=0, and rd equals id_rs1 or id_rs2; or
  - is_fp and rd equals any of id_fp_rs1..3 (f0 is a real register).
- The issuing op itself is not compared in its issue cycle; the existing EX-stage combinational check covers that cycle.
- Integer rd==x0 is recorded but never matches.
- fp_pending = slot_busy[2].
- stall_cycles increments by 1 on each cycle with raw_stall=1 and holds at all-ones.
- Latency: issue visible on slot_busy/raw_stall one cycle after the issue edge. The stall clears WB_DELAY cycles after the cycle in which done is sampled.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, stall_cycles=0.
- Issue M rd=x5; assert done 4 cycles later; hold id_rs1=5 throughout -> raw_stall=1 from the cycle after issue through WB_DELAY(=1) cycle after done, then 0; stall_cycles=5.
- Issue A rd=x0, id_rs1=0 -> raw_stall stays 0, slot_busy[1]=1 until done+1.
- Issue FPU rd=f0 fp; id_fp_rs3=0, id_rs1=0 -> raw_stall=1 (FP match), fp_pending=1; integer-only ID source with FP slot -> raw_stall=0.
- Issue M while M BUSY with same-cycle unit_done[0] -> issue_stall=1, slot goes WB_PENDING, not re-BUSY; reissue after IDLE accepted.
- All three slots BUSY, assert flush with done[1] and an issue -> next cycle slot_busy=000, raw_stall=0. Also: reset_n pulled low mid-op -> immediate clear.
